// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a ready-handshake memory port,
// holds the fetched word for the decoder and picks the next PC from its controls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  selbrjumpz,
  input  logic [1:0]  selpctype,
  input  logic        cond,
  input  logic [31:0] rs_value,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  fn,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {START, FETCH, VALID, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic [7:0]  wait_cnt;
  logic        timeout_hit;
  logic        unused_rs_low;

  assign imem_addr     = pc;
  assign op            = instr[31:26];
  assign fn            = instr[5:0];
  assign br_off        = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign unused_rs_low = ^rs_value[1:0];

  // The wait that would bring the count up to TIMEOUT is the one that gives up.
  assign timeout_hit = (TIMEOUT != 8'd0) &&
                       (({1'b0, wait_cnt} + 9'd1) == {1'b0, TIMEOUT});

  always_comb begin
    next_pc = pc_plus4;
    case (selbrjumpz)
      2'b01: begin
        if (selpctype == 2'b10)
          next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (selpctype == 2'b01)
          next_pc = {rs_value[31:2], 2'b00};
      end
      2'b10: begin
        if (cond)
          next_pc = pc_plus4 + br_off;
      end
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= START;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      pc_plus4    <= RESET_PC + 32'd4;
      fetch_err   <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      case (state)
        START: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= 8'd0;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            pc_plus4    <= pc + 32'd4;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= VALID;
          end else if (timeout_hit) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        VALID: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            wait_cnt    <= 8'd0;
            state       <= FETCH;
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
